// File: rtl/aes_128_key_schedule.sv
// AES-128 key expansion: cipher key in, eleven round keys out.
// Ports: clk, rst (async high), in_key[127:0], sk0..sk10[127:0].
// The whole 10-round chain is combinational. Only the round key
// outputs are registered, giving one key set per cycle and a
// latency of one cycle.
module aes_128_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_key,
    output logic [127:0] sk0,
    output logic [127:0] sk1,
    output logic [127:0] sk2,
    output logic [127:0] sk3,
    output logic [127:0] sk4,
    output logic [127:0] sk5,
    output logic [127:0] sk6,
    output logic [127:0] sk7,
    output logic [127:0] sk8,
    output logic [127:0] sk9,
    output logic [127:0] sk10
);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants for rounds 1..10, round 1 in the top byte.
    localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

    // Entry b lives at bit offset (255 - b) * 8, i.e. {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx  = {~b, 3'b000};
        sbox = SBOX_TBL[idx +: 8];
    endfunction

    logic [31:0] w [44];

    assign w[0] = in_key[127:96];
    assign w[1] = in_key[95:64];
    assign w[2] = in_key[63:32];
    assign w[3] = in_key[31:0];

    for (genvar r = 1; r <= 10; r++) begin : g_round
        logic [31:0] rot;
        logic [31:0] sub;
        logic [7:0]  rc;

        // RotWord: first byte moves to the end.
        assign rot = {w[4*r-1][23:0], w[4*r-1][31:24]};
        assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                      sbox(rot[15:8]),  sbox(rot[7:0])};
        assign rc  = RCON_TBL[79-8*(r-1) -: 8];

        assign w[4*r]   = w[4*r-4] ^ sub ^ {rc, 24'h0};
        assign w[4*r+1] = w[4*r-3] ^ w[4*r];
        assign w[4*r+2] = w[4*r-2] ^ w[4*r+1];
        assign w[4*r+3] = w[4*r-1] ^ w[4*r+2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk0  <= '0;
            sk1  <= '0;
            sk2  <= '0;
            sk3  <= '0;
            sk4  <= '0;
            sk5  <= '0;
            sk6  <= '0;
            sk7  <= '0;
            sk8  <= '0;
            sk9  <= '0;
            sk10 <= '0;
        end else begin
            sk0  <= {w[0],  w[1],  w[2],  w[3]};
            sk1  <= {w[4],  w[5],  w[6],  w[7]};
            sk2  <= {w[8],  w[9],  w[10], w[11]};
            sk3  <= {w[12], w[13], w[14], w[15]};
            sk4  <= {w[16], w[17], w[18], w[19]};
            sk5  <= {w[20], w[21], w[22], w[23]};
            sk6  <= {w[24], w[25], w[26], w[27]};
            sk7  <= {w[28], w[29], w[30], w[31]};
            sk8  <= {w[32], w[33], w[34], w[35]};
            sk9  <= {w[36], w[37], w[38], w[39]};
            sk10 <= {w[40], w[41], w[42], w[43]};
        end
    end

endmodule

// File: tb/tb_aes_128_key_schedule.sv
// Testbench for aes_128_key_schedule.
// Reference model derives the S-box from GF(2^8) arithmetic.
module tb_aes_128_key_schedule;

    logic         clk;
    logic         rst;
    logic [127:0] in_key;
    logic [127:0] sk [11];

    aes_128_key_schedule dut (
        .clk    (clk),
        .rst    (rst),
        .in_key (in_key),
        .sk0    (sk[0]),
        .sk1    (sk[1]),
        .sk2    (sk[2]),
        .sk3    (sk[3]),
        .sk4    (sk[4]),
        .sk5    (sk[5]),
        .sk6    (sk[6]),
        .sk7    (sk[7]),
        .sk8    (sk[8]),
        .sk9    (sk[9]),
        .sk10   (sk[10])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    logic [7:0]   ref_sbox [256];
    logic [7:0]   ref_rcon [11];
    logic [127:0] exp_ks   [11];
    logic [127:0] fips_ks  [11];

    localparam logic [127:0] FIPS_KEY =
        128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v,
                                         input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01)
                    inv = 8'(y);
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                        ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc = 8'h01;
        ref_rcon[0] = 8'h00;
        for (int j = 1; j <= 10; j++) begin
            ref_rcon[j] = rc;
            rc = gmul(rc, 8'h02);
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++)
            w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]],
                     ref_sbox[t[15:8]],  ref_sbox[t[7:0]]};
                t = t ^ {ref_rcon[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 11; n++)
            exp_ks[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        for (int n = 0; n < 11; n++)
            check($sformatf("%s sk%0d", tag, n), sk[n], exp_ks[n]);
    endtask

    task automatic check_zero(input string tag);
        for (int n = 0; n < 11; n++)
            check($sformatf("%s sk%0d", tag, n), sk[n], 128'h0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] key;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        build_tables();

        fips_ks[0]  = FIPS_KEY;
        fips_ks[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_ks[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_ks[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_ks[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_ks[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_ks[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_ks[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_ks[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_ks[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_ks[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset asserted away from a clock edge.
        rst    = 1'b0;
        in_key = rand128();
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        tick();
        tick();
        check_zero("rst_hold");
        rst = 1'b0;
        in_key = FIPS_KEY;
        #1 check_zero("rst_release");

        // FIPS-197 vector.
        tick();
        for (int n = 0; n < 11; n++)
            check($sformatf("fips sk%0d", n), sk[n], fips_ks[n]);
        expand(FIPS_KEY);
        check_model("fips_model");

        // Key change between edges must not reach outputs.
        in_key = rand128();
        #2 for (int n = 0; n < 11; n++)
            check($sformatf("hold sk%0d", n), sk[n], fips_ks[n]);

        // Back-to-back: zero key then FIPS key.
        in_key = 128'h0;
        tick();
        in_key = FIPS_KEY;
        check("zero sk1", sk[1],
              128'h62636363626363636263636362636363);
        check("zero sk2", sk[2],
              128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
        check("zero sk10", sk[10],
              128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        expand(128'h0);
        check_model("zero_model");
        tick();
        for (int n = 0; n < 11; n++)
            check($sformatf("b2b sk%0d", n), sk[n], fips_ks[n]);

        // Mid-stream reset while outputs hold the FIPS set.
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        key    = rand128();
        in_key = key;
        tick();
        check_zero("mid_rst_hold");
        #2 rst = 1'b0;
        tick();
        expand(key);
        check_model("post_rst");

        // Random keys, one per cycle.
        for (int c = 0; c < 200; c++) begin
            key    = rand128();
            in_key = key;
            tick();
            expand(key);
            check_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
